classify_argmax: RTL and testbench
==================================

# classify_argmax

Post-softmax classification stage. Captures the 10-lane probability vector from the softmax unit and scans it serially for the winning class and its confidence. Presents the result on a valid/ready handshake, flags low-confidence decisions and keeps per-class decision counters for on-board accuracy monitoring. Sits directly downstream of the softmax unit and upstream of the result/readout logic.

## Interface
- N_CLASSES, 10: number of lanes in the input vector.
- W, 16: lane width; unsigned, Q1.15 probability scale (0x8000 = 1.0).
- CONF_THRESH, 16'h2000: confidence below this (0.25) sets low_conf.
- CNT_W, 16: width of each per-class decision counter.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- softmax_in  in  N_CLASSES*W  probability vector; lane i = bits [i*W +: W].
- in_valid  in  1  single-cycle strobe; softmax_in valid this cycle; cannot be back-pressured.
- class_idx  out  4  winning lane index.
- confidence  out  W  winning lane value.
- low_conf  out  1  confidence < CONF_THRESH.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result when out_valid & out_ready.
- busy  out  1  state != IDLE or pending buffer full.
- overflow  out  1  sticky; an input vector was dropped.
- hist_sel  in  4  counter select.
- hist_count  out  CNT_W  combinational read of counter[hist_sel]; 0 if hist_sel >= N_CLASSES.
- hist_clr  in  1  synchronous clear of all counters and overflow.

## Operation
- Storage: scan buffer (N_CLASSES*W), one-deep pending buffer + pending_full flag, best_val/best_idx, lane counter, N_CLASSES saturating counters.
- FSM states: IDLE, SCAN, HOLD.
- IDLE: if pending_full, move pending to the scan buffer, clear pending_full, go to SCAN. Otherwise, if in_valid, capture softmax_in into the scan buffer and go to SCAN.
- SCAN: one lane per cycle, lane 0 first. Lane 0 loads best unconditionally. Lane i>0 replaces best only if strictly greater (unsigned). Ties therefore go to the lowest index.
- After lane N_CLASSES-1: register class_idx, confidence and low_conf; set out_valid; go to HOLD.
- HOLD: out_valid stays high and outputs stay stable until out_ready. On handshake: clear out_valid, increment counter[class_idx] (saturates at 2^CNT_W-1), go to IDLE.
- in_valid while not capturing in IDLE:
  - pending empty → write pending.
  - pending full and being drained into the scan buffer the same edge → write pending (no drop).
  - otherwise → drop the vector and set overflow.
- hist_clr zeroes all counters and overflow. If it coincides with a handshake, clear wins and there is no increment.
- All-zero vector → class_idx 0, confidence 0, low_conf 1.

## Timing
- Reset (async, any state, mid-scan included): state IDLE, out_valid 0, class_idx 0, confidence 0, low_conf 0, overflow 0, busy 0, pending_full 0, all counters 0. Any in-flight vector is discarded.
- Latency: in_valid sampled at edge E0. Lanes compared at edges E1..E10. out_valid rises at E10, i.e. N_CLASSES cycles after capture.
- out_ready held high: handshake at E11, back in IDLE. A pending vector enters SCAN at E12. Steady-state throughput is one vector per N_CLASSES+2 cycles.
- out_ready is ignored while out_valid=0.
- Results are never dropped; only input vectors can be dropped, and only when pending is full.
- busy is registered and reflects state after the edge.
- The softmax out_valid pulse connects directly to in_valid, with no glue.

## Test plan
- Lanes = {0x0100, 0x0200, 0x6000, 0x0300, 0, 0, 0, 0, 0, 0x1000}, out_ready=1 → out_valid at E10; class_idx=2, confidence=0x6000, low_conf=0; counter[2]=1.
- Tie: lanes 3 and 7 both 0x4000, rest 0x0100 → class_idx=3. All-zero vector → class_idx=0, low_conf=1.
- out_ready=0 for 20 cycles, then send a second and a third in_valid → first result held stable and second vector in pending; the third is dropped and overflow=1. Release out_ready → second result follows; overflow stays sticky.
- Pending full; in_valid lands on the exact edge pending drains into SCAN → no drop, overflow stays 0, three results delivered in order.
- Assert rst_n low at SCAN lane 5, release → all outputs at reset values; a new vector after release gives a correct result at E10.
- Force counter[4] to 0xFFFF via repeated class-4 handshakes → stays 0xFFFF. hist_clr on the same cycle as a handshake → all counters 0, overflow 0. hist_sel=12 → hist_count=0.

Source files
------------

// File: rtl/classify_argmax.sv
// rtl/classify_argmax.sv - serial argmax over a softmax probability vector with result handshake and per-class counters
module classify_argmax #(
    parameter int             N_CLASSES   = 10,
    parameter int             W           = 16,
    parameter logic [W-1:0]   CONF_THRESH = 16'h2000,
    parameter int             CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CLASSES*W-1:0] softmax_in,
    input  logic                   in_valid,
    output logic [3:0]             class_idx,
    output logic [W-1:0]           confidence,
    output logic                   low_conf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   overflow,
    input  logic [3:0]             hist_sel,
    output logic [CNT_W-1:0]       hist_count,
    input  logic                   hist_clr
);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    localparam logic [3:0]       LAST_LANE = 4'(N_CLASSES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t                 state, state_nxt;
    logic [N_CLASSES*W-1:0] scan_buf;
    logic [N_CLASSES*W-1:0] pend_buf;
    logic                   pending_full, pend_full_nxt;
    logic [W-1:0]           best_val;
    logic [3:0]             best_idx;
    logic [3:0]             lane_cnt;
    logic [CNT_W-1:0]       cnt [N_CLASSES];

    logic                   drain, capture, pend_wr, drop, handshake;
    logic                   take_lane;
    logic [W-1:0]           lane_val, win_val;
    logic [3:0]             win_idx;

    // Admission decisions, next-state and the running winner for the lane under scan
    always_comb begin
        drain         = (state == IDLE) && pending_full;
        capture       = (state == IDLE) && !pending_full && in_valid;
        // A full pending slot can be refilled on the same edge it drains
        pend_wr       = in_valid && !capture && (!pending_full || drain);
        drop          = in_valid && !capture && pending_full && !drain;
        handshake     = (state == HOLD) && out_valid && out_ready;
        pend_full_nxt = pend_wr ? 1'b1 : (drain ? 1'b0 : pending_full);

        lane_val  = scan_buf[lane_cnt*W +: W];
        // Strict compare keeps the lowest index on ties; lane 0 seeds the scan
        take_lane = (lane_cnt == 4'd0) || (lane_val > best_val);
        win_val   = take_lane ? lane_val : best_val;
        win_idx   = take_lane ? lane_cnt : best_idx;

        state_nxt = state;
        case (state)
            IDLE:    if (drain || capture) state_nxt = SCAN;
            SCAN:    if (lane_cnt == LAST_LANE) state_nxt = HOLD;
            HOLD:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Main FSM: capture/drain, serial scan, registered result held until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            scan_buf     <= '0;
            pend_buf     <= '0;
            pending_full <= 1'b0;
            best_val     <= '0;
            best_idx     <= 4'd0;
            lane_cnt     <= 4'd0;
            class_idx    <= 4'd0;
            confidence   <= '0;
            low_conf     <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nxt;
            pending_full <= pend_full_nxt;
            busy         <= (state_nxt != IDLE) || pend_full_nxt;
            if (pend_wr) pend_buf <= softmax_in;
            case (state)
                IDLE: begin
                    lane_cnt <= 4'd0;
                    if (drain) scan_buf <= pend_buf;
                    else if (capture) scan_buf <= softmax_in;
                end
                SCAN: begin
                    best_val <= win_val;
                    best_idx <= win_idx;
                    lane_cnt <= lane_cnt + 4'd1;
                    if (lane_cnt == LAST_LANE) begin
                        class_idx  <= win_idx;
                        confidence <= win_val;
                        low_conf   <= (win_val < CONF_THRESH);
                        out_valid  <= 1'b1;
                    end
                end
                HOLD: if (handshake) out_valid <= 1'b0;
                default: ;
            endcase
            // Clear takes priority over a drop on the same edge
            if (hist_clr) overflow <= 1'b0;
            else if (drop) overflow <= 1'b1;
        end
    end

    // Saturating per-class decision counters; clear beats a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CLASSES; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CLASSES; i++) begin
                if (hist_clr) cnt[i] <= '0;
                else if (handshake && (class_idx == 4'(i)) && (cnt[i] != CNT_MAX))
                    cnt[i] <= cnt[i] + CNT_ONE;
            end
        end
    end

    // Combinational counter readback, zero for out-of-range selects
    always_comb begin
        hist_count = '0;
        for (int i = 0; i < N_CLASSES; i++)
            if (hist_sel == 4'(i)) hist_count = cnt[i];
    end

endmodule

// File: tb/tb_classify_argmax.sv
// tb/tb_classify_argmax.sv - self-checking bench for classify_argmax
module tb_classify_argmax;

    localparam int N     = 10;
    localparam int W     = 16;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [3:0]   idx;
        logic [W-1:0] conf;
        logic         low;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N*W-1:0]   softmax_in = '0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             hist_clr = 1'b0;
    logic [3:0]       hist_sel = 4'd0;
    logic [3:0]       class_idx;
    logic [W-1:0]     confidence;
    logic             low_conf, out_valid, busy, overflow;
    logic [CNT_W-1:0] hist_count;
    logic             exp_drop = 1'b0;

    int   n_checks = 0;
    int   n_fail = 0;
    res_t q[$];
    int   m_cnt[N];
    logic m_ovf = 1'b0;

    classify_argmax #(.N_CLASSES(N), .W(W), .CONF_THRESH(16'h2000), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .softmax_in(softmax_in), .in_valid(in_valid),
        .class_idx(class_idx), .confidence(confidence), .low_conf(low_conf),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overflow(overflow),
        .hist_sel(hist_sel), .hist_count(hist_count), .hist_clr(hist_clr)
    );

    always #20 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: highest probability wins, earliest lane on ties
    function automatic res_t ref_argmax(input logic [N*W-1:0] v);
        res_t r;
        logic [W-1:0] lanes [N];
        for (int i = 0; i < N; i++) lanes[i] = v[i*W +: W];
        r.idx  = 4'd0;
        r.conf = lanes[0];
        for (int i = 1; i < N; i++)
            if (lanes[i] > r.conf) begin
                r.idx  = 4'(i);
                r.conf = lanes[i];
            end
        r.low = (r.conf < 16'h2000);
        return r;
    endfunction

    function automatic logic [N*W-1:0] mk(input int pk, input logic [W-1:0] pv, input logic [W-1:0] base);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = (i == pk) ? pv : base;
        return v;
    endfunction

    // Per-cycle compare against the model, then advance the model for the coming edge
    always @(negedge clk) begin
        int   e;
        res_t r;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_class_idx", class_idx, 0);
            chk("rst_confidence", confidence, 0);
            chk("rst_low_conf", low_conf, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_hist_count", hist_count, 0);
            q.delete();
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_ovf = 1'b0;
        end else begin
            chk("busy", busy, (q.size() != 0));
            chk("overflow", overflow, m_ovf);
            e = (hist_sel < N) ? m_cnt[hist_sel] : 0;
            chk("hist_count", hist_count, e);
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL result_unexpected: got out_valid 1 expected no pending result at %0t", $time);
                end else begin
                    chk("res_class_idx", class_idx, q[0].idx);
                    chk("res_confidence", confidence, q[0].conf);
                    chk("res_low_conf", low_conf, q[0].low);
                end
            end
            if (in_valid) begin
                if (exp_drop) m_ovf = 1'b1;
                else q.push_back(ref_argmax(softmax_in));
            end
            if (out_valid && out_ready && q.size() != 0) begin
                r = q.pop_front();
                if (!hist_clr && m_cnt[r.idx] < CMAX) m_cnt[r.idx]++;
            end
            if (hist_clr) begin
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
                m_ovf = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N*W-1:0] v, input logic drop);
        softmax_in = v;
        in_valid   = 1'b1;
        exp_drop   = drop;
        tick();
        in_valid   = 1'b0;
        exp_drop   = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 60) begin
            tick();
            k++;
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || out_valid) && k < 200) begin
            tick();
            k++;
        end
        chk("wait_idle", busy, 0);
    endtask

    initial begin
        logic [N*W-1:0] v;
        int k;

        #1 rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Basic vector, latency and counter
        out_ready = 1'b1;
        v = '0;
        v[0*W +: W] = 16'h0100; v[1*W +: W] = 16'h0200; v[2*W +: W] = 16'h6000;
        v[3*W +: W] = 16'h0300; v[9*W +: W] = 16'h1000;
        send(v, 1'b0);
        wait_valid(k);
        chk("t1_latency", k, 10);
        chk("t1_class_idx", class_idx, 2);
        chk("t1_confidence", confidence, 16'h6000);
        chk("t1_low_conf", low_conf, 0);
        hist_sel = 4'd2;
        tick();
        chk("t1_hist2", hist_count, 1);

        // Tie, all-zero and threshold boundary
        v = mk(3, 16'h4000, 16'h0100);
        v[7*W +: W] = 16'h4000;
        send(v, 1'b0);
        wait_valid(k);
        chk("tie_class_idx", class_idx, 3);
        chk("tie_confidence", confidence, 16'h4000);
        tick();
        send('0, 1'b0);
        wait_valid(k);
        chk("zero_class_idx", class_idx, 0);
        chk("zero_confidence", confidence, 0);
        chk("zero_low_conf", low_conf, 1);
        tick();
        send(mk(8, 16'h1fff, 16'h0100), 1'b0);
        wait_valid(k);
        chk("thr_below_low", low_conf, 1);
        tick();
        send(mk(6, 16'h2000, 16'h0100), 1'b0);
        wait_valid(k);
        chk("thr_at_low", low_conf, 0);
        tick();

        // Back-pressure: hold, pending fill, drop
        out_ready = 1'b0;
        send(mk(5, 16'h3000, 16'h0010), 1'b0);
        repeat (20) tick();
        send(mk(1, 16'h7000, 16'h0010), 1'b0);
        send(mk(8, 16'h5000, 16'h0010), 1'b1);
        chk("bp_overflow", overflow, 1);
        chk("bp_held_idx", class_idx, 5);
        out_ready = 1'b1;
        wait_idle();
        chk("bp_overflow_sticky", overflow, 1);

        // Refill pending on the same edge it drains: no drop
        hist_clr = 1'b1;
        tick();
        hist_clr = 1'b0;
        send(mk(0, 16'h7fff, 16'h0001), 1'b0);
        send(mk(9, 16'h4444, 16'h0001), 1'b0);
        repeat (10) tick();
        send(mk(4, 16'h2222, 16'h0001), 1'b0);
        wait_idle();
        chk("drain_overflow", overflow, 0);

        // Reset in the middle of a scan
        send(mk(7, 16'h6000, 16'h0100), 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        send(mk(6, 16'h3333, 16'h0100), 1'b0);
        wait_valid(k);
        chk("rst_latency", k, 10);
        chk("rst_class_idx_after", class_idx, 6);
        tick();

        // Saturate counter 4
        hist_sel = 4'd4;
        for (int n = 0; n < CMAX + 2; n++) begin
            send(mk(4, 16'h5000, 16'h0100), 1'b0);
            wait_valid(k);
            tick();
        end
        chk("sat_hist4", hist_count, CMAX);

        // Clear coinciding with a handshake, with overflow set
        out_ready = 1'b0;
        send(mk(1, 16'h5000, 16'h0100), 1'b0);
        wait_valid(k);
        send(mk(6, 16'h5000, 16'h0100), 1'b0);
        send(mk(2, 16'h5000, 16'h0100), 1'b1);
        chk("clr_pre_overflow", overflow, 1);
        hist_clr  = 1'b1;
        out_ready = 1'b1;
        tick();
        hist_clr  = 1'b0;
        for (int i = 0; i < N; i++) begin
            hist_sel = 4'(i);
            #1;
            chk("clr_hist", hist_count, 0);
        end
        chk("clr_overflow", overflow, 0);
        hist_sel = 4'd12;
        #1;
        chk("sel12_hist", hist_count, 0);
        wait_idle();
        hist_sel = 4'd6;
        #1;
        chk("post_clr_hist6", hist_count, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
